// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered data_out / data_valid / frame_err / busy outputs.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             fall_s;

    // A start is a 1->0 step of the synchronized line; a line held low after
    // a break never produces one until it has gone high again.
    assign fall_s = rx_prev_q & ~rx_sync_q;

    // Next-state, bit timing and output pulse generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && fall_s) begin
                    state_d = S_START;
                    bit_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!rx_sync_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_sync_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_sync_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, synchronizer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; a negedge monitor counts
// output pulses and busy cycles, each scenario task compares against fixed expectations.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         busy_cyc = 0;
    int         pulse_viol = 0;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;
    logic [7:0] dv_log[$];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx),
        .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse and busy bookkeeping, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_log.push_back(data_out);
        end
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (busy === 1'b1) busy_cyc = busy_cyc + 1;
        if ((data_valid === 1'b1) && (frame_err === 1'b1)) pulse_viol = pulse_viol + 1;
        if ((data_valid === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe))
            pulse_viol = pulse_viol + 1;
        prev_dv = (data_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic drop_en);
        bit_period(1'b0);
        if (drop_en) en = 1'b0;
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; rx = 1'b1;
        wait_clks(3);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_single;
        int dv0 = dv_cnt;
        int fe0 = fe_cnt;
        int bc0 = busy_cyc;
        send_frame(8'h34, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
        total++; if (data_out !== 8'h34) begin bad++; $display("FAIL single_data: got %h want 34", data_out); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_fe_count: got %0d want 0", fe_cnt - fe0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
        total++; if (busy_cyc - bc0 < 90 || busy_cyc - bc0 > 100) begin bad++; $display("FAIL single_busy_len: got %0d want 90..100", busy_cyc - bc0); end
    endtask

    task automatic test_back_to_back;
        int dv0 = dv_cnt;
        int n0  = dv_log.size();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (dv_cnt - dv0 !== 2) begin bad++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); end
        if (dv_log.size() >= n0 + 2) begin
            total++; if (dv_log[n0] !== 8'h55) begin bad++; $display("FAIL b2b_first: got %h want 55", dv_log[n0]); end
            total++; if (dv_log[n0+1] !== 8'hAA) begin bad++; $display("FAIL b2b_second: got %h want aa", dv_log[n0+1]); end
        end else begin
            total++; bad++; $display("FAIL b2b_log: got %0d bytes want 2", dv_log.size() - n0);
        end
        total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL b2b_data_out: got %h want aa", data_out); end
    endtask

    task automatic test_glitch;
        int dv0 = dv_cnt;
        int fe0 = fe_cnt;
        int bc0 = busy_cyc;
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(30);
        total++; if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_pulses: got dv=%0d fe=%0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
        total++; if (busy_cyc - bc0 < 1 || busy_cyc - bc0 > 7) begin bad++; $display("FAIL glitch_busy_len: got %0d want 1..7", busy_cyc - bc0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_frame_err;
        int dv0, fe0;
        send_frame(8'h34, 1'b1, 1'b0);
        wait_clks(5);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        wait_clks(8);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_fe_count: got %0d want 1", fe_cnt - fe0); end
        total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL ferr_dv_count: got %0d want 0", dv_cnt - dv0); end
        total++; if (data_out !== 8'h34) begin bad++; $display("FAIL ferr_data_hold: got %h want 34", data_out); end
    endtask

    task automatic test_break;
        int fe0 = fe_cnt;
        int bc0;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(1'b0);
        bit_period(1'b0);
        bc0 = busy_cyc;
        wait_clks(40);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break_fe_count: got %0d want 1", fe_cnt - fe0); end
        total++; if (busy_cyc - bc0 !== 0) begin bad++; $display("FAIL break_no_restart: got %0d busy cycles want 0", busy_cyc - bc0); end
        rx = 1'b1;
        wait_clks(20);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL break_recover: got %h want 3c", data_out); end
    endtask

    task automatic test_reset_midframe;
        int dv0, fe0;
        logic [7:0] b = 8'hC3;
        bit_period(1'b0);
        for (int i = 0; i < 3; i++) bit_period(b[i]);
        rx = b[3];
        wait_clks(5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got busy=%b data=%h dv=%b fe=%b want 0 00 0 0", busy, data_out, data_valid, frame_err);
        end
        dv0 = dv_cnt; fe0 = fe_cnt;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(30);
        total++; if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) begin bad++; $display("FAIL rst_mid_no_pulse: got dv=%0d fe=%0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL rst_mid_next_dv: got %0d want 1", dv_cnt - dv0); end
        total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL rst_mid_next_data: got %h want 0f", data_out); end
    endtask

    task automatic test_enable;
        int dv0 = dv_cnt;
        int fe0 = fe_cnt;
        int bc0 = busy_cyc;
        en = 1'b0;
        send_frame(8'h12, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) begin bad++; $display("FAIL en_off_pulses: got dv=%0d fe=%0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
        total++; if (busy_cyc - bc0 !== 0) begin bad++; $display("FAIL en_off_busy: got %0d busy cycles want 0", busy_cyc - bc0); end
        en = 1'b1;
        wait_clks(5);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_clks(8);
        total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL en_on_dv: got %0d want 1", dv_cnt - dv0); end
        total++; if (data_out !== 8'h12) begin bad++; $display("FAIL en_on_data: got %h want 12", data_out); end
        send_frame(8'h81, 1'b1, 1'b1);
        wait_clks(8);
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL en_drop_midframe: got %h want 81", data_out); end
        en = 1'b1;
        wait_clks(5);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_midframe();
        test_enable();
        total++; if (pulse_viol !== 0) begin bad++; $display("FAIL pulse_shape: got %0d violations want 0", pulse_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); the block SHALL support any CLKS_PER_BIT >= 4.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  receive enable; when low, no new frame is started.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 data_out  output  8  last correctly framed byte received.
REQ-009 data_valid  output  1  one-clock pulse when data_out is updated.
REQ-010 frame_err  output  1  one-clock pulse when the stop bit is sampled low.
REQ-011 busy  output  1  high while a frame is being received.

Function
REQ-012 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 rx SHALL pass through a two-flop synchronizer (rx_sync) before any use; both flops reset to 1.
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-015 IDLE: when en=1 and rx_sync goes from 1 to 0, the block SHALL enter START with the bit counter cleared; no other event leaves IDLE.
REQ-016 START: after CLKS_PER_BIT/2 clocks, rx_sync is sampled; 0 -> DATA with counter cleared, 1 -> IDLE with no output activity (glitch rejection).
REQ-017 DATA: every CLKS_PER_BIT clocks rx_sync is shifted into a shift register at bit index 0..7, LSB first; after the 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT clocks rx_sync is sampled; 1 -> data_out loaded from the shift register and data_valid high for exactly the next clock; 0 -> frame_err high for exactly the next clock and data_out unchanged; either case -> IDLE.
REQ-019 data_valid and frame_err SHALL never be high in the same clock, and neither SHALL be high for more than one consecutive clock.
REQ-020 data_out SHALL hold its value between data_valid pulses.
REQ-021 busy SHALL be 0 in IDLE and 1 in START, DATA and STOP.
REQ-022 A frame that is in progress when en falls SHALL complete normally; en is checked only in IDLE.
REQ-023 After a framing error with rx held low (break), no new frame SHALL start until rx_sync has returned high and then falls again.
REQ-024 Back-to-back frames (next start bit immediately after the stop bit) SHALL be received without loss.
REQ-025 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL restart at 0 on every state transition.

Reset
REQ-026 While rst_n=0: state=IDLE, counters=0, shift register=0, data_out=8'h00, data_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-027 Asserting rst_n mid-frame SHALL abort the frame with no data_valid or frame_err pulse; reception resumes on the first falling edge after release.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, 10 clocks/bit, en=1 unless stated)
REQ-028 Send 0x34 with valid stop -> exactly one data_valid pulse, data_out=0x34, frame_err never high, busy low afterwards.
REQ-029 Send 0x55 then 0xAA with no idle gap -> two data_valid pulses, data_out=0x55 then 0xAA.
REQ-030 3-clock low glitch on idle rx -> no data_valid or frame_err; busy high for at most 7 clocks, then 0.
REQ-031 Send 0xA5 with stop bit 0 after a good 0x34 -> one frame_err pulse, no data_valid, data_out stays 0x34.
REQ-032 rst_n low for 5 clocks during bit 3 of 0xC3 -> all outputs 0 immediately; next frame 0x0F -> data_valid, data_out=0x0F.
REQ-033 en=0 while 0x12 is sent -> no pulses, busy stays 0; en=1, send 0x12 again -> data_valid, data_out=0x12.
